// File: rtl/bidir_dir_ctrl_if.sv
// Handshake and pad-cell bundle for one half-duplex BIDIR pad controller.
// master: fabric requesters plus the pad cell's IZ return path.
// slave:  the direction controller itself.
interface bidir_dir_ctrl_if;
   logic wr_req;
   logic wr_dat;
   logic wr_ack;
   logic rd_req;
   logic rd_ack;
   logic rd_dat;
   logic IE;
   logic INEN;
   logic OQI;
   logic IZ;
   logic busy;

   modport master (
      output wr_req, wr_dat, rd_req, IZ,
      input  wr_ack, rd_ack, rd_dat, IE, INEN, OQI, busy
   );

   modport slave (
      input  wr_req, wr_dat, rd_req, IZ,
      output wr_ack, rd_ack, rd_dat, IE, INEN, OQI, busy
   );
endinterface

// File: rtl/bidir_dir_ctrl.sv
// Half-duplex direction controller for one BIDIR pad in INOUT mode.
// Arbitrates write/read requesters round-robin, inserts turnaround dead
// cycles on every direction change and drives the cell's IE/INEN/OQI.
module bidir_dir_ctrl #(
   parameter int unsigned TURN_CYCLES = 2,
   parameter int unsigned RD_DELAY    = 1
) (
   input logic             IQC,
   input logic             IQRN,
   bidir_dir_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, TURN, DRIVE, WAIT_RD, SAMPLE} state_t;
   typedef enum logic {DIR_IN, DIR_OUT} dir_t;
   typedef enum logic {GNT_RD, GNT_WR} gnt_t;

   localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
   localparam logic [3:0] RD_LOAD   = (RD_DELAY == 0) ? 4'd0 : 4'(RD_DELAY - 1);

   state_t     state, state_nx;
   dir_t       dir, dir_nx;
   gnt_t       last_grant, last_nx;
   gnt_t       pend, pend_nx;
   logic [3:0] cnt, cnt_nx;
   logic       wr_bit, wr_bit_nx;
   logic       wr_cand, rd_cand, grant_wr;

   logic ie_q, inen_q, oqi_q, wr_ack_q, rd_ack_q, rd_dat_q, busy_q;
   logic ie_nx, inen_nx, oqi_nx, wr_ack_nx, rd_ack_nx, rd_dat_nx, busy_nx;

   assign bus.IE     = ie_q;
   assign bus.INEN   = inen_q;
   assign bus.OQI    = oqi_q;
   assign bus.wr_ack = wr_ack_q;
   assign bus.rd_ack = rd_ack_q;
   assign bus.rd_dat = rd_dat_q;
   assign bus.busy   = busy_q;

   // State, direction, arbitration history and the latched write bit.
   always_ff @(posedge IQC or negedge IQRN) begin
      if (!IQRN) begin
         state      <= IDLE;
         dir        <= DIR_IN;
         last_grant <= GNT_RD;
         pend       <= GNT_RD;
         cnt        <= '0;
         wr_bit     <= 1'b0;
      end else begin
         state      <= state_nx;
         dir        <= dir_nx;
         last_grant <= last_nx;
         pend       <= pend_nx;
         cnt        <= cnt_nx;
         wr_bit     <= wr_bit_nx;
      end
   end

   // Next-state: arbitration in IDLE, turnaround and read-settle counting.
   always_comb begin
      state_nx  = state;
      dir_nx    = dir;
      last_nx   = last_grant;
      pend_nx   = pend;
      cnt_nx    = cnt;
      wr_bit_nx = wr_bit;
      grant_wr  = 1'b0;
      // A requester is masked in its own ack cycle so a held req is not regranted.
      wr_cand   = bus.wr_req && !wr_ack_q;
      rd_cand   = bus.rd_req && !rd_ack_q;
      unique case (state)
         IDLE: begin
            if (wr_cand || rd_cand) begin
               grant_wr = wr_cand && (!rd_cand || last_grant == GNT_RD);
               pend_nx  = grant_wr ? GNT_WR : GNT_RD;
               last_nx  = grant_wr ? GNT_WR : GNT_RD;
               if (grant_wr) wr_bit_nx = bus.wr_dat;
               if (grant_wr != (dir == DIR_OUT)) begin
                  state_nx = TURN;
                  cnt_nx   = TURN_LOAD;
               end else if (grant_wr) begin
                  state_nx = DRIVE;
               end else if (RD_DELAY == 0) begin
                  state_nx = SAMPLE;
               end else begin
                  state_nx = WAIT_RD;
                  cnt_nx   = RD_LOAD;
               end
            end
         end
         TURN: begin
            if (cnt == 4'd0) begin
               dir_nx = (dir == DIR_OUT) ? DIR_IN : DIR_OUT;
               if (pend == GNT_WR) begin
                  state_nx = DRIVE;
               end else if (RD_DELAY == 0) begin
                  state_nx = SAMPLE;
               end else begin
                  state_nx = WAIT_RD;
                  cnt_nx   = RD_LOAD;
               end
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         DRIVE:   state_nx = IDLE;
         WAIT_RD: begin
            if (cnt == 4'd0) state_nx = SAMPLE;
            else             cnt_nx   = cnt - 4'd1;
         end
         SAMPLE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output is a flop.
   always_comb begin
      ie_nx     = 1'b0;
      inen_nx   = 1'b0;
      oqi_nx    = 1'b0;
      wr_ack_nx = 1'b0;
      rd_ack_nx = (state == SAMPLE);
      rd_dat_nx = (state == SAMPLE) ? bus.IZ : rd_dat_q;
      busy_nx   = (state_nx != IDLE);
      unique case (state_nx)
         IDLE: begin
            ie_nx   = (dir_nx == DIR_OUT);
            inen_nx = (dir_nx == DIR_IN);
            oqi_nx  = (dir_nx == DIR_OUT) ? wr_bit_nx : 1'b0;
         end
         TURN: ;
         DRIVE: begin
            ie_nx     = 1'b1;
            oqi_nx    = wr_bit_nx;
            wr_ack_nx = 1'b1;
         end
         WAIT_RD, SAMPLE: inen_nx = 1'b1;
         default: ;
      endcase
   end

   // Registered pad controls and handshake outputs.
   always_ff @(posedge IQC or negedge IQRN) begin
      if (!IQRN) begin
         ie_q     <= 1'b0;
         inen_q   <= 1'b1;
         oqi_q    <= 1'b0;
         wr_ack_q <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_dat_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         ie_q     <= ie_nx;
         inen_q   <= inen_nx;
         oqi_q    <= oqi_nx;
         wr_ack_q <= wr_ack_nx;
         rd_ack_q <= rd_ack_nx;
         rd_dat_q <= rd_dat_nx;
         busy_q   <= busy_nx;
      end
   end

endmodule
